// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit.
//   state_t    : sequencer states (IDLE, RUN, DONE)
//   NIB_W      : width of one processed slice (4 bits)
//   idx_width(): width of the nibble index counter for a given operand width
package nibble_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIB_W = 4;

    // clog2 of the nibble count, but never narrower than one bit so the
    // counter stays a legal vector even for the smallest operand width.
    function automatic int idx_width(input int width);
        int nib;
        nib = width / NIB_W;
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4.sv
// 4-bit carry-lookahead adder slice.
// Ports:
//   a, b  : 4-bit addends
//   SEL   : carry in
//   Sum   : 4-bit sum
//   Cout  : carry out of bit 3
module adderCLA4b (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       SEL,
    output logic [3:0] Sum,
    output logic       Cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is expanded directly from generate/propagate terms and
    // the carry in, so no carry depends on a lower-order carry signal.
    assign c[0] = SEL;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sum
            assign Sum[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    assign Cout = c[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit add/subtract unit built on a single 4-bit lookahead
// slice. One nibble is processed per clock, least significant first, with
// the carry held in a register between nibbles.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (a, b, SEL, op_sub)
//   a, b                  : WIDTH-bit operands
//   SEL                   : carry in for add mode (ignored when op_sub=1)
//   op_sub                : 1 computes a - b as a + ~b + 1
//   out_valid / out_ready : result handshake (Sum, Cout, Ovf)
//   Sum                   : WIDTH-bit result
//   Cout                  : carry out of MSB (subtract: 1 = no borrow)
//   Ovf                   : two's-complement signed overflow
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int NIB   = WIDTH / NIB_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             SEL,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int IDX_W = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    generate
        if (((WIDTH % NIB_W) != 0) || (WIDTH < 8)) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    state_t            state_reg;
    state_t            state_next;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  sum_reg;
    logic              carry_reg;
    logic              ovf_reg;
    logic [IDX_W-1:0]  idx_reg;

    logic [NIB_W-1:0]  a_nib;
    logic [NIB_W-1:0]  b_nib;
    logic [NIB_W-1:0]  slice_sum;
    logic              slice_cout;
    logic              accept;
    logic              last_nib;

    assign a_nib    = a_reg[NIB_W*idx_reg +: NIB_W];
    assign b_nib    = b_reg[NIB_W*idx_reg +: NIB_W];
    assign accept   = (state_reg == IDLE) && in_valid;
    assign last_nib = (idx_reg == LAST_IDX);

    adderCLA4b u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .SEL  (carry_reg),
        .Sum  (slice_sum),
        .Cout (slice_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and handshake decodes; in_ready/out_valid depend on the
    // state only, so neither handshake input reaches an output combinationally.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_nib) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch and nibble datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            idx_reg   <= '0;
        end else if (accept) begin
            a_reg     <= a;
            // Subtraction is a + ~b + 1: the inversion is folded into the
            // stored operand and the +1 becomes the initial carry.
            b_reg     <= op_sub ? ~b : b;
            carry_reg <= op_sub ? 1'b1 : SEL;
            sum_reg   <= '0;
            ovf_reg   <= 1'b0;
            idx_reg   <= '0;
        end else if (state_reg == RUN) begin
            sum_reg[NIB_W*idx_reg +: NIB_W] <= slice_sum;
            carry_reg <= slice_cout;
            if (last_nib) begin
                // The top slice's MSB is the result sign; overflow when both
                // effective operands share a sign the result does not.
                ovf_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                           (slice_sum[NIB_W-1] != a_reg[WIDTH-1]);
            end else begin
                idx_reg <= idx_reg + IDX_W'(1);
            end
        end
    end

    assign Sum  = sum_reg;
    assign Cout = carry_reg;
    assign Ovf  = ovf_reg;

endmodule
